// File: rtl/seven_segment_mux_n_if.sv
// seven_segment_mux_n_if: display data, mode controls and pin-side outputs
// of the multiplexed seven-segment controller.
interface seven_segment_mux_n_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DUTY_BITS  = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en_in;
    logic                    load;
    logic                    hex_mode;
    logic                    blank_leading;
    logic [DUTY_BITS-1:0]    brightness;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output digits_in, dp_in, digit_en_in, load,
        output hex_mode, blank_leading, brightness,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  digits_in, dp_in, digit_en_in, load,
        input  hex_mode, blank_leading, brightness,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seven_segment_mux_n.sv
// seven_segment_mux_n: N-digit time-multiplexed 7-segment driver with
// double-buffered digit banks, leading-zero blanking and PWM brightness.
module seven_segment_mux_n #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DUTY_BITS   = 4
) (
    input logic                 clk,
    input logic                 rst,
    seven_segment_mux_n_if.slave bus
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] S_LAST = SW'(NUM_DIGITS - 1);
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] DASH  = 7'b0111111;

    logic [RW-1:0]         refresh_cnt;
    logic [SW-1:0]         scan_idx;
    logic [DUTY_BITS-1:0]  pwm_cnt;
    logic                  pend_valid;
    logic [DW-1:0]         pend_digits;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic [NUM_DIGITS-1:0] pend_en;
    logic [DW-1:0]         act_digits;
    logic [NUM_DIGITS-1:0] act_dp;
    logic [NUM_DIGITS-1:0] act_en;

    logic                  slot_end;
    logic                  wrap;
    logic [3:0]            cur_digit;
    logic                  upper_zero;
    logic                  blanked;
    logic                  show;
    logic                  lit;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    function automatic logic [6:0] glyph(input logic [3:0] v, input logic hex);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            4'hF: g = 7'b0001110;
        endcase
        if (!hex && v > 4'd9) begin
            g = DASH;
        end
        return g;
    endfunction

    assign slot_end = (refresh_cnt == R_LAST);
    assign wrap     = slot_end && (scan_idx == S_LAST);

    // Slot timer, digit scan pointer and free-running PWM phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
            pwm_cnt     <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (slot_end) begin
                refresh_cnt <= '0;
                scan_idx    <= wrap ? '0 : scan_idx + 1'b1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
        end
    end

    // Pending bank takes loads; active bank swaps only at the frame wrap,
    // with a load on the wrap cycle going straight into the active bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid  <= 1'b0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_en     <= '0;
            act_digits  <= '0;
            act_dp      <= '0;
            act_en      <= '0;
        end else begin
            if (bus.load) begin
                pend_digits <= bus.digits_in;
                pend_dp     <= bus.dp_in;
                pend_en     <= bus.digit_en_in;
            end
            if (wrap) begin
                pend_valid <= 1'b0;
                if (bus.load) begin
                    act_digits <= bus.digits_in;
                    act_dp     <= bus.dp_in;
                    act_en     <= bus.digit_en_in;
                end else if (pend_valid) begin
                    act_digits <= pend_digits;
                    act_dp     <= pend_dp;
                    act_en     <= pend_en;
                end
            end else if (bus.load) begin
                pend_valid <= 1'b1;
            end
        end
    end

    // Blanking, anode gating and glyph selection for the scanned digit.
    always_comb begin
        upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (SW'(j) >= scan_idx && act_digits[4*j +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        cur_digit = act_digits[{scan_idx, 2'b00} +: 4];
        blanked   = bus.blank_leading && (scan_idx != '0) && upper_zero;
        show      = act_en[scan_idx] && !blanked;
        lit       = (pwm_cnt <= bus.brightness);
        seg_next  = show ? glyph(cur_digit, bus.hex_mode) : BLANK;
        an_next   = '1;
        if (show && lit) begin
            an_next[scan_idx] = 1'b0;
        end
    end

    // Registered pin drivers and frame-wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.an         <= '1;
            bus.seg        <= BLANK;
            bus.dp         <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            bus.an         <= an_next;
            bus.seg        <= seg_next;
            bus.dp         <= ~act_dp[scan_idx];
            bus.frame_done <= wrap;
        end
    end
endmodule

// File: tb/tb_seven_segment_mux_n.sv
// tb_seven_segment_mux_n: directed frame-by-frame checks of the 4-digit
// display controller against expected pin patterns queued per frame.
module tb_seven_segment_mux_n;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int DB = 2;

    localparam logic [6:0] G0  = 7'b1000000;
    localparam logic [6:0] G1  = 7'b1111001;
    localparam logic [6:0] G2  = 7'b0100100;
    localparam logic [6:0] G3  = 7'b0110000;
    localparam logic [6:0] G4  = 7'b0011001;
    localparam logic [6:0] G5  = 7'b0010010;
    localparam logic [6:0] GA  = 7'b0001000;
    localparam logic [6:0] GDS = 7'b0111111;
    localparam logic [6:0] BLK = 7'h7F;
    localparam logic [12:0] RST_OUT = {4'hF, 7'h7F, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seven_segment_mux_n_if #(.NUM_DIGITS(ND), .DUTY_BITS(DB)) bus();

    seven_segment_mux_n #(
        .NUM_DIGITS(ND),
        .REFRESH_DIV(RD),
        .DUTY_BITS(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    logic [12:0] exp_q[$];

    task automatic chk(input string tag, input logic [12:0] exp);
        logic [12:0] obs;
        obs = {bus.an, bus.seg, bus.dp, bus.frame_done};
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: an/seg/dp/fd got %b/%b/%b/%b expected %b/%b/%b/%b",
                   tag, obs[12:9], obs[8:2], obs[1], obs[0],
                   exp[12:9], exp[8:2], exp[1], exp[0]);
        end
    endtask

    // segs = {digit3, digit2, digit1, digit0}; on = digits that drive anodes
    task automatic push_frame(input logic [27:0] segs, input logic [3:0] on,
                              input logic [3:0] dps, input int bright);
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 4; p++) begin
                logic [3:0] a;
                logic       fd;
                a = 4'hF;
                if (on[k] && p <= bright) a[k] = 1'b0;
                fd = (k == 3 && p == 3);
                exp_q.push_back({a, segs[7*k +: 7], ~dps[k], fd});
            end
        end
    endtask

    // 16 samples of one frame; optional one-cycle load after sample load_at.
    task automatic check_frame(input string tag, input int load_at);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                total_cnt++;
                fail_cnt++;
                $error("FAIL %s[%0d]: scoreboard empty, got nothing expected entry", tag, i);
            end else begin
                chk($sformatf("%s[%0d]", tag, i), exp_q.pop_front());
            end
            bus.load = (i == load_at);
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.digits_in     = '0;
        bus.dp_in         = '0;
        bus.digit_en_in   = '0;
        bus.load          = 1'b0;
        bus.hex_mode      = 1'b0;
        bus.blank_leading = 1'b0;
        bus.brightness    = '0;

        @(negedge clk);
        chk("reset", RST_OUT);
        @(negedge clk);
        @(negedge clk);
        chk("reset_hold", RST_OUT);
        rst = 1'b0;

        push_frame({4{BLK}}, 4'h0, 4'h0, 3);
        check_frame("idle0", -1);
        push_frame({4{BLK}}, 4'h0, 4'h0, 3);
        check_frame("idle1", -1);

        bus.digits_in   = 16'h1234;
        bus.digit_en_in = 4'hF;
        bus.brightness  = 2'd3;
        push_frame({4{BLK}}, 4'h0, 4'h0, 3);
        check_frame("idle2", 2);

        bus.hex_mode  = 1'b1;
        bus.digits_in = 16'h00A5;
        push_frame({G1, G2, G3, G4}, 4'hF, 4'h0, 3);
        check_frame("scan", 5);

        push_frame({G0, G0, GA, G5}, 4'hF, 4'h0, 3);
        check_frame("hex", -1);

        bus.hex_mode = 1'b0;
        push_frame({G0, G0, GDS, G5}, 4'hF, 4'h0, 3);
        check_frame("dec", -1);

        bus.blank_leading = 1'b1;
        bus.digits_in     = 16'h1111;
        push_frame({BLK, BLK, GDS, G5}, 4'b0011, 4'h0, 3);
        check_frame("blank", 7);

        bus.blank_leading = 1'b0;
        bus.digits_in     = 16'h2222;
        push_frame({4{G1}}, 4'hF, 4'h0, 3);
        check_frame("ones", 6);

        bus.digits_in = 16'h3333;
        push_frame({4{G2}}, 4'hF, 4'h0, 3);
        check_frame("twos", 14);

        push_frame({4{G3}}, 4'hF, 4'h0, 3);
        check_frame("threes_wrap", -1);

        bus.digits_in   = 16'h1234;
        bus.digit_en_in = 4'b0101;
        bus.dp_in       = 4'b0001;
        push_frame({4{G3}}, 4'hF, 4'h0, 3);
        check_frame("threes_hold", 3);

        bus.brightness = 2'd1;
        push_frame({BLK, G2, BLK, G4}, 4'b0101, 4'b0001, 1);
        check_frame("dim", -1);

        repeat (9) @(negedge clk);
        chk("pre_rst_slot2", {4'b1011, G2, 1'b1, 1'b0});
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid", RST_OUT);
        rst = 1'b0;

        push_frame({4{BLK}}, 4'h0, 4'h0, 1);
        check_frame("post_rst0", -1);
        push_frame({4{BLK}}, 4'h0, 4'h0, 1);
        check_frame("post_rst1", -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
